// File: rtl/ddr_port1_reader.sv
// ddr_port1_reader
//   Streams one frame buffer out of DDR through MCB port 1 into the display
//   pipeline. A frame is fetched as a series of read bursts, one burst in
//   flight at a time; each returned word is handed downstream through a
//   single-entry valid/ready output register.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   mem_calib_done      MCB calibration done (asynchronous, synchronised here)
//   display_frame       buffer select sampled on an accepted frame_start
//   frame_start         one-cycle frame request from display timing
//   p1_cmd_*            MCB port-1 command channel (read only)
//   p1_rd_*             MCB port-1 read data FIFO
//   pixel_data/valid    word to the display pipeline, pixel_ready accepts it
//   frame_late          sticky: a frame_start arrived outside WAIT_FRAME
module ddr_port1_reader #(
  parameter int FRAME_WORDS = 17640,
  parameter int BURST_WORDS = 32,
  parameter int BASE_A      = 0,
  parameter int BASE_B      = 70560
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic        display_frame,
  input  logic        frame_start,
  output logic        p1_cmd_en,
  output logic [2:0]  p1_cmd_instr,
  output logic [5:0]  p1_cmd_bl,
  output logic [29:0] p1_cmd_byte_addr,
  input  logic        p1_cmd_full,
  output logic        p1_rd_en,
  input  logic [31:0] p1_rd_data,
  input  logic        p1_rd_empty,
  output logic [31:0] pixel_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_late
);

  // Index must be able to hold FRAME_WORDS itself (end-of-frame compare).
  localparam int IW = $clog2(FRAME_WORDS + 1);
  // Common width for burst arithmetic: wide enough for both the index and 64.
  localparam int CW = (IW > 7) ? IW : 7;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ISSUE, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            calib_meta, calib_sync;
  logic [IW-1:0]   index;
  logic [IW-1:0]   index_next;
  logic [29:0]     base;
  logic [CW-1:0]   remaining, burst_n, word_cnt;
  logic            drain_pop, last_pop;

  assign p1_cmd_instr = 3'b001;

  // Words left in the frame and size of the current burst. index is frozen
  // from ISSUE through DRAIN, so burst_n stays constant for the whole burst.
  assign remaining  = CW'(FRAME_WORDS) - CW'(index);
  assign burst_n    = (remaining < CW'(BURST_WORDS)) ? remaining : CW'(BURST_WORDS);
  assign index_next = IW'(CW'(index) + burst_n);
  assign last_pop   = drain_pop && (word_cnt + CW'(1) == burst_n);

  always_comb begin
    state_nxt        = state;
    p1_cmd_en        = 1'b0;
    p1_cmd_bl        = 6'd0;
    p1_cmd_byte_addr = 30'd0;
    p1_rd_en         = 1'b0;
    drain_pop        = 1'b0;
    case (state)
      IDLE: begin
        // Flush anything left in the read FIFO (e.g. data from a burst
        // abandoned by reset) so the next frame starts clean.
        p1_rd_en = !p1_rd_empty;
        if (calib_sync) state_nxt = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (frame_start) state_nxt = ISSUE;
      end
      ISSUE: begin
        p1_cmd_bl        = 6'(burst_n - CW'(1));
        p1_cmd_byte_addr = base + (30'(index) << 2);
        if (!p1_cmd_full) begin
          p1_cmd_en = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Pop only when the output register is free or being emptied this
        // cycle; word_cnt guard keeps us from reading past our own burst.
        drain_pop = !p1_rd_empty && (!pixel_valid || pixel_ready) && (word_cnt < burst_n);
        p1_rd_en  = drain_pop;
        if (last_pop)
          state_nxt = (index_next == IW'(FRAME_WORDS)) ? WAIT_FRAME : ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      calib_meta  <= 1'b0;
      calib_sync  <= 1'b0;
      index       <= '0;
      base        <= 30'd0;
      word_cnt    <= '0;
      pixel_data  <= 32'd0;
      pixel_valid <= 1'b0;
      frame_late  <= 1'b0;
    end else begin
      state      <= state_nxt;
      calib_meta <= mem_calib_done;
      calib_sync <= calib_meta;

      if (state == WAIT_FRAME && frame_start) begin
        base     <= display_frame ? 30'(BASE_B) : 30'(BASE_A);
        index    <= '0;
        word_cnt <= '0;
      end

      // A pop reloads the output register even if the old word is being
      // accepted in the same cycle, so back-to-back words flow without gaps.
      if (drain_pop) begin
        pixel_data  <= p1_rd_data;
        pixel_valid <= 1'b1;
        if (last_pop) begin
          word_cnt <= '0;
          index    <= index_next;
        end else begin
          word_cnt <= word_cnt + CW'(1);
        end
      end else if (pixel_valid && pixel_ready) begin
        pixel_valid <= 1'b0;
      end

      // Any request outside WAIT_FRAME is late, including one that lands on
      // the cycle the final word is popped (state is still DRAIN then).
      if (frame_start && state != WAIT_FRAME) frame_late <= 1'b1;
    end
  end

endmodule
